// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the Booth multiply arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_mul_pkg;

    localparam int BOOTH_WIDTH = 4;
    localparam int BOOTH_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {found, index}: the first set request searching upward from last+1, with wrap.
    // Requests are packed into 8 bits so one function serves every legal NREQ.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input int       nreq,
                                           input logic [2:0] last);
        logic [3:0] r;
        int         idx;
        r = '0;
        // Walk from the farthest candidate to the nearest so the nearest one is left standing.
        for (int k = 8; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (int'(last) + k) % nreq;
                if (req[3'(idx)]) begin
                    r = {1'b1, 3'(idx)};
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier datapath: M, acc, Q, Q(-1) and step counter.
// Latency: WIDTH step cycles after load; product port shows the value after the current step.
// Backpressure: none; it only advances when step is asserted.
module booth_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 step,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             qm1_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;

    // acc carries one guard bit so subtracting M = -2^(WIDTH-1) cannot overflow.
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
        acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt   = {sum[0], q_q[WIDTH-1:1]};
        done    = step && (cnt_q == CW'(1));
        product = {acc_nxt[WIDTH-1:0], q_nxt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            acc_q <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            m_q   <= {a[WIDTH-1], a};
            acc_q <= '0;
            q_q   <= b;
            qm1_q <= 1'b0;
            cnt_q <= CW'(WIDTH);
        end else if (step) begin
            acc_q <= acc_nxt;
            q_q   <= q_nxt;
            qm1_q <= q_q[0];
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one Booth multiplier among NREQ requesters; optional BOOTH_MUL_ARB_ZERO_SKIP_EN.
// Latency: grant to rsp_valid is WIDTH+1 cycles (1 cycle for zero operands when the macro is defined).
// Backpressure: product held in DONE until rsp_ready; no requests accepted while a product is pending.
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH,
    parameter int NREQ  = BOOTH_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_grant_q;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     win_idx;
    logic               win_vld;
    logic [7:0]         req_ext;
    logic [2:0]         lg_ext;
    logic [3:0]         pick;
    logic [WIDTH-1:0]   grant_a;
    logic [WIDTH-1:0]   grant_b;
    logic               zero_op;
    logic               seq_load;
    logic               seq_step;
    logic               seq_done;
    logic [2*WIDTH-1:0] seq_product;

    always_comb begin
        req_ext              = '0;
        req_ext[NREQ-1:0]    = req_valid;
        lg_ext               = '0;
        lg_ext[IDW-1:0]      = last_grant_q;
        pick                 = rr_pick(req_ext, NREQ, lg_ext);
        win_vld              = pick[3];
        win_idx              = IDW'(pick[2:0]);
        grant_a              = '0;
        grant_b              = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                grant_a = req_a[i*WIDTH +: WIDTH];
                grant_b = req_b[i*WIDTH +: WIDTH];
            end
        end
`ifdef BOOTH_MUL_ARB_ZERO_SKIP_EN
        zero_op = (grant_a == '0) || (grant_b == '0);
`else
        zero_op = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // req_ready is forced low while reset is held so a stalled requester never sees a grant.
    always_comb begin
        state_d   = state_q;
        seq_load  = 1'b0;
        seq_step  = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    req_ready[win_idx] = rst_n;
                    seq_load           = 1'b1;
                    state_d            = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                seq_step = 1'b1;
                if (seq_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_product  <= '0;
        end else begin
            if (seq_load) begin
                last_grant_q <= win_idx;
                id_q         <= win_idx;
            end
            if (seq_load && zero_op) begin
                rsp_valid   <= 1'b1;
                rsp_id      <= win_idx;
                rsp_product <= '0;
            end else if (seq_done) begin
                rsp_valid   <= 1'b1;
                rsp_id      <= id_q;
                rsp_product <= seq_product;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    booth_mul_seq #(
        .WIDTH (WIDTH)
    ) u_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (seq_load),
        .a       (grant_a),
        .b       (grant_b),
        .step    (seq_step),
        .done    (seq_done),
        .product (seq_product)
    );

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one iterative radix-2 Booth multiply unit among NREQ requesters. It accepts one signed operand pair at a time over per-requester valid/ready handshakes and runs the Booth recurrence for WIDTH cycles. It then returns the signed 2·WIDTH-bit product, tagged with the requester index, on a single response channel. It sits between the control-path clients and the arithmetic datapath, replacing per-client combinational multipliers.

## Interface
- WIDTH, 4, operand width in bits, two's complement; legal range 2..16
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), width of the requester index
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester accept; at most one bit high (one-hot or zero)
- req_a  input  NREQ*WIDTH  multiplicands, signed; slice i belongs to requester i
- req_b  input  NREQ*WIDTH  multipliers, signed; slice i belongs to requester i
- rsp_valid  output  1  product valid
- rsp_ready  input  1  consumer accepts the product
- rsp_id  output  IDW  index of the requester that owns the product
- rsp_product  output  2*WIDTH  signed product

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching upward, with wrap, from last_grant+1.
  - Assert req_ready for that bit only, combinationally, in the same cycle.
  - On that edge, latch M = sign-extended req_a and Q = req_b. Clear the accumulator and the Q(-1) bit. Load step counter = WIDTH. Record the id, update last_grant, and go to RUN.
- RUN, one Booth step per cycle:
  - {Q[0],Q(-1)} = 01: acc += M.
  - {Q[0],Q(-1)} = 10: acc -= M.
  - Otherwise acc is unchanged.
  - Then arithmetic-shift {acc,Q,Q(-1)} right by one and decrement the counter.
  - After the WIDTH-th step, go to DONE.
- Width rule: acc is WIDTH+1 bits, so M = −2^(WIDTH−1) subtraction cannot overflow. Product = {acc[WIDTH−1:0], Q}, exact for every operand pair.
- DONE:
  - rsp_valid = 1. rsp_id and rsp_product stay stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge, go to IDLE.
- req_ready is 0 in RUN and DONE. Requests are never accepted while a product is pending.
- A requester whose req_valid drops before it is granted is simply skipped. Operands are sampled only in the grant cycle.
- Reset (at any time, including mid-RUN or mid-DONE):
  - state = IDLE; last_grant = NREQ−1, so requester 0 wins first.
  - rsp_valid = 0, rsp_id = 0, rsp_product = 0, req_ready = 0, counter = 0.
  - Any in-flight operation is discarded with no response.

## Timing
- Grant cycle T (IDLE, handshake) → RUN in cycles T+1..T+WIDTH → rsp_valid high from T+WIDTH+1.
- Minimum issue interval is WIDTH+2 cycles, reached when rsp_ready is held high.
- rsp_valid, rsp_id and rsp_product are registered. req_ready is combinational from state, req_valid and last_grant.
- Simultaneous requests: strict rotation. No requester waits more than NREQ−1 other grants.

## Configuration
- Macro: BOOTH_MUL_ARB_ZERO_SKIP_EN.
- Defined:
  - In the grant cycle, if req_a == 0 or req_b == 0, skip RUN and enter DONE directly with product 0 (latency 1).
  - All other operand pairs behave as above.
- Undefined: every operation takes the full WIDTH RUN cycles; no zero detection logic is built.

## Structure
- Package booth_mul_pkg:
  - state enum (IDLE/RUN/DONE)
  - default WIDTH/NREQ constants
  - a function returning the round-robin winner given a request vector and last_grant
- Sub-module booth_mul_seq:
  - holds M/acc/Q/Q(-1)/counter
  - ports: load, operands, step enable, done, product
- booth_mul_arbiter keeps the FSM, grant logic, id register and response register.

## Test plan
- Single request: reset, requester 2 sends a=3, b=−2 → req_ready[2] high for one cycle; rsp_valid 5 cycles later (WIDTH=4); product −6 (8'hFA), rsp_id=2.
- Corner operands: requester 0 sends a=−8, b=−8 → product 64. Then a=−8, b=7 → −56. Then a=7, b=7 → 49.
- Fairness: all four req_valid held high with rsp_ready=1 → grants in order 0,1,2,3,0; one grant every 6 cycles.
- Backpressure: rsp_ready=0 for 10 cycles in DONE → rsp_valid, rsp_id and rsp_product held constant and req_ready stays 0. Releasing rsp_ready completes the handshake, and IDLE grants the next request one cycle later.
- Reset mid-RUN: assert rst_n=0 two cycles into RUN → all outputs 0 immediately with no response produced. After release, requester 0 wins the first grant.
- Zero skip (with BOOTH_MUL_ARB_ZERO_SKIP_EN): a=0, b=5 → rsp_valid one cycle after grant, product 0. Without the macro, same stimulus → rsp_valid after 5 cycles, product 0.
